// File: rtl/dtlb_refill_if.sv
// Handshake and TLB write-port bundle between the DTLB refill sequencer (slave)
// and the pipes / page walker / TLB array around it (master).
interface dtlb_refill_if #(
    parameter int DATA_W = 64,
    parameter int VA_W   = 51
);
    logic              miss_valid;
    logic              miss_ready;
    logic [VA_W-1:0]   miss_addr;
    logic              inv_valid;
    logic              inv_ready;
    logic [VA_W-1:0]   inv_addr;
    logic              walk_req_valid;
    logic              walk_req_ready;
    logic [VA_W-1:0]   walk_req_addr;
    logic              walk_rsp_valid;
    logic              walk_rsp_fault;
    logic [DATA_W-1:0] walk_rsp_data0;
    logic [DATA_W-1:0] walk_rsp_data1;
    logic [DATA_W-1:0] walk_rsp_data2;
    logic              write_wen;
    logic [VA_W-1:0]   write_addr;
    logic [DATA_W-1:0] write_data0;
    logic [DATA_W-1:0] write_data1;
    logic [DATA_W-1:0] write_data2;
    logic              write_xstant;
    logic              write_invl;
    logic              fill_done;

    modport slave (
        input  miss_valid, miss_addr, inv_valid, inv_addr,
        input  walk_req_ready, walk_rsp_valid, walk_rsp_fault,
        input  walk_rsp_data0, walk_rsp_data1, walk_rsp_data2,
        output miss_ready, inv_ready, walk_req_valid, walk_req_addr,
        output write_wen, write_addr, write_data0, write_data1, write_data2,
        output write_xstant, write_invl, fill_done
    );

    modport master (
        output miss_valid, miss_addr, inv_valid, inv_addr,
        output walk_req_ready, walk_rsp_valid, walk_rsp_fault,
        output walk_rsp_data0, walk_rsp_data1, walk_rsp_data2,
        input  miss_ready, inv_ready, walk_req_valid, walk_req_addr,
        input  write_wen, write_addr, write_data0, write_data1, write_data2,
        input  write_xstant, write_invl, fill_done
    );
endinterface

// File: rtl/dtlb_refill.sv
// DTLB refill sequencer: dedups and queues misses, runs one page walk at a time,
// and writes fills or invalidations into the TLB write port.
module dtlb_refill #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int VA_W   = 51
) (
    input  logic           clk,
    input  logic           rst,
    dtlb_refill_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_INVL} state_t;

    state_t            state, state_nxt;
    logic [VA_W-1:0]   q_addr [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic [VA_W-1:0]   flight_addr, inv_addr_q;
    logic              inv_pending, kill, rsp_fault_q;
    logic [DATA_W-1:0] rsp_d0_q, rsp_d1_q, rsp_d2_q;
    logic              in_flight, dup_hit, push, pop, inv_hs, fill_invl;

    assign in_flight      = (state == S_REQ) || (state == S_WAIT) || (state == S_FILL);
    assign bus.miss_ready = (count != FULL_CNT);
    assign bus.inv_ready  = ~inv_pending;
    assign inv_hs         = bus.inv_valid && ~inv_pending;
    assign pop            = (state == S_IDLE) && ~inv_pending && (count != '0);
    assign push           = bus.miss_valid && bus.miss_ready && ~dup_hit;
    assign fill_invl      = rsp_fault_q | kill;

    always_comb begin
        dup_hit = in_flight && (flight_addr == bus.miss_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == bus.miss_addr)) dup_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_addr[wr_ptr] <= bus.miss_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_vld       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            flight_addr <= '0;
        end else begin
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
                flight_addr   <= q_addr[rd_ptr];
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // A matching invalidate that lands in FILL is not kept as kill: the INVL
    // that follows covers that page, and a stale kill would poison the next walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inv_pending <= 1'b0;
            inv_addr_q  <= '0;
            kill        <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_d0_q    <= '0;
            rsp_d1_q    <= '0;
            rsp_d2_q    <= '0;
        end else begin
            if (inv_hs) begin
                inv_pending <= 1'b1;
                inv_addr_q  <= bus.inv_addr;
            end else if (state == S_INVL) begin
                inv_pending <= 1'b0;
            end
            if (state == S_FILL)
                kill <= 1'b0;
            else if (inv_hs && in_flight && (bus.inv_addr == flight_addr))
                kill <= 1'b1;
            if ((state == S_WAIT) && bus.walk_rsp_valid) begin
                rsp_fault_q <= bus.walk_rsp_fault;
                rsp_d0_q    <= bus.walk_rsp_data0;
                rsp_d1_q    <= bus.walk_rsp_data1;
                rsp_d2_q    <= bus.walk_rsp_data2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.walk_req_valid = 1'b0;
        bus.walk_req_addr  = '0;
        bus.write_wen      = 1'b0;
        bus.write_addr     = '0;
        bus.write_data0    = '0;
        bus.write_data1    = '0;
        bus.write_data2    = '0;
        bus.write_xstant   = 1'b0;
        bus.write_invl     = 1'b0;
        bus.fill_done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (inv_pending)       state_nxt = S_INVL;
                else if (count != '0)  state_nxt = S_REQ;
            end
            S_REQ: begin
                bus.walk_req_valid = 1'b1;
                bus.walk_req_addr  = flight_addr;
                if (bus.walk_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.walk_rsp_valid) state_nxt = S_FILL;
            end
            S_FILL: begin
                bus.write_wen   = 1'b1;
                bus.write_addr  = flight_addr;
                bus.write_invl  = fill_invl;
                bus.write_data0 = fill_invl ? '0 : rsp_d0_q;
                bus.write_data1 = fill_invl ? '0 : rsp_d1_q;
                bus.write_data2 = fill_invl ? '0 : rsp_d2_q;
                bus.fill_done   = 1'b1;
                state_nxt       = S_IDLE;
            end
            S_INVL: begin
                bus.write_wen    = 1'b1;
                bus.write_addr   = inv_addr_q;
                bus.write_xstant = 1'b1;
                bus.write_invl   = 1'b1;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dtlb_refill.sv
// Directed bench for dtlb_refill: a per-cycle vector table for fill, fault and
// kill/invalidate timing, plus sequences for dedup, queue wrap and mid-walk reset.
module tb_dtlb_refill;
    localparam int VA_W   = 51;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;

    typedef struct {
        logic              mv;
        logic [VA_W-1:0]   ma;
        logic              iv;
        logic [VA_W-1:0]   ia;
        logic              wrr;
        logic              rv;
        logic              rf;
        logic [DATA_W-1:0] rd0, rd1, rd2;
        logic              e_mr, e_ir, e_wrv;
        logic [VA_W-1:0]   e_wra;
        logic              e_wen;
        logic [VA_W-1:0]   e_wa;
        logic [DATA_W-1:0] e_wd0, e_wd1, e_wd2;
        logic              e_xs, e_invl, e_fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [VA_W-1:0] walk_log[$];
    int   wen_cnt  = 0;
    int   fill_cnt = 0;
    vec_t vecs[21];

    dtlb_refill_if #(.DATA_W(DATA_W), .VA_W(VA_W)) bus();

    dtlb_refill #(.DEPTH(DEPTH), .DATA_W(DATA_W), .VA_W(VA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.walk_req_valid && bus.walk_req_ready) walk_log.push_back(bus.walk_req_addr);
        if (bus.write_wen) wen_cnt++;
        if (bus.fill_done) fill_cnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t stim(input logic mv, input logic [VA_W-1:0] ma,
                                  input logic iv, input logic [VA_W-1:0] ia,
                                  input logic rv, input logic rf,
                                  input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                  input logic [DATA_W-1:0] d2);
        vec_t v;
        v.mv = mv;  v.ma = ma;  v.iv = iv;  v.ia = ia;  v.wrr = 1'b1;
        v.rv = rv;  v.rf = rf;  v.rd0 = d0; v.rd1 = d1; v.rd2 = d2;
        v.e_mr = 1'b1; v.e_ir = 1'b1; v.e_wrv = 1'b0; v.e_wra = '0;
        v.e_wen = 1'b0; v.e_wa = '0; v.e_wd0 = '0; v.e_wd1 = '0; v.e_wd2 = '0;
        v.e_xs = 1'b0; v.e_invl = 1'b0; v.e_fd = 1'b0;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.miss_valid     = v.mv;
        bus.miss_addr      = v.ma;
        bus.inv_valid      = v.iv;
        bus.inv_addr       = v.ia;
        bus.walk_req_ready = v.wrr;
        bus.walk_rsp_valid = v.rv;
        bus.walk_rsp_fault = v.rf;
        bus.walk_rsp_data0 = v.rd0;
        bus.walk_rsp_data1 = v.rd1;
        bus.walk_rsp_data2 = v.rd2;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("v%0d_miss_ready", idx), 64'(bus.miss_ready), 64'(v.e_mr));
        check($sformatf("v%0d_inv_ready", idx), 64'(bus.inv_ready), 64'(v.e_ir));
        check($sformatf("v%0d_walk_req_valid", idx), 64'(bus.walk_req_valid), 64'(v.e_wrv));
        check($sformatf("v%0d_write_wen", idx), 64'(bus.write_wen), 64'(v.e_wen));
        check($sformatf("v%0d_fill_done", idx), 64'(bus.fill_done), 64'(v.e_fd));
        if (v.e_wrv)
            check($sformatf("v%0d_walk_req_addr", idx), 64'(bus.walk_req_addr), 64'(v.e_wra));
        if (v.e_wen) begin
            check($sformatf("v%0d_write_addr", idx), 64'(bus.write_addr), 64'(v.e_wa));
            check($sformatf("v%0d_write_data0", idx), bus.write_data0, v.e_wd0);
            check($sformatf("v%0d_write_data1", idx), bus.write_data1, v.e_wd1);
            check($sformatf("v%0d_write_data2", idx), bus.write_data2, v.e_wd2);
            check($sformatf("v%0d_write_xstant", idx), 64'(bus.write_xstant), 64'(v.e_xs));
            check($sformatf("v%0d_write_invl", idx), 64'(bus.write_invl), 64'(v.e_invl));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quietInputs();
        bus.miss_valid     = 1'b0;
        bus.inv_valid      = 1'b0;
        bus.walk_rsp_valid = 1'b0;
        bus.walk_rsp_fault = 1'b0;
    endtask

    // Walker model: answers every accepted request in the following cycle.
    task automatic runWalks(input int ncyc);
        logic hs;
        bus.walk_req_ready = 1'b1;
        repeat (ncyc) begin
            @(negedge clk);
            hs = bus.walk_req_valid && bus.walk_req_ready;
            cycle();
            bus.walk_rsp_valid = hs;
            bus.walk_rsp_fault = 1'b0;
            bus.walk_rsp_data0 = 64'h5A;
        end
        bus.walk_rsp_valid = 1'b0;
    endtask

    initial begin
        int fill0, wen0;

        vecs[0]  = stim(1, 51'h1234, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2].e_wrv = 1; vecs[2].e_wra = 51'h1234;
        vecs[3]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = stim(0, 0, 0, 0, 1, 0, 64'hA, 64'hB, 64'hC);
        vecs[6]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6].e_wen = 1; vecs[6].e_wa = 51'h1234; vecs[6].e_fd = 1;
        vecs[6].e_wd0 = 64'hA; vecs[6].e_wd1 = 64'hB; vecs[6].e_wd2 = 64'hC;
        vecs[7]  = stim(1, 51'h40, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9].e_wrv = 1; vecs[9].e_wra = 51'h40;
        vecs[10] = stim(0, 0, 0, 0, 1, 1, 64'hFF, 64'hEE, 64'hDD);
        vecs[11] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11].e_wen = 1; vecs[11].e_wa = 51'h40; vecs[11].e_invl = 1; vecs[11].e_fd = 1;
        vecs[12] = stim(1, 51'h40, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14].e_wrv = 1; vecs[14].e_wra = 51'h40;
        vecs[15] = stim(0, 0, 1, 51'h40, 0, 0, 0, 0, 0);
        vecs[16] = stim(0, 0, 0, 0, 1, 0, 64'h1, 64'h2, 64'h3);
        vecs[16].e_ir = 0;
        vecs[17] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17].e_ir = 0; vecs[17].e_wen = 1; vecs[17].e_wa = 51'h40;
        vecs[17].e_invl = 1; vecs[17].e_fd = 1;
        vecs[18] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18].e_ir = 0;
        vecs[19] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[19].e_ir = 0; vecs[19].e_wen = 1; vecs[19].e_wa = 51'h40;
        vecs[19].e_xs = 1; vecs[19].e_invl = 1;
        vecs[20] = stim(0, 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(stim(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.walk_req_ready = 1'b0;
        rst = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        check("rst_inv_ready", 64'(bus.inv_ready), 64'd1);
        check("rst_walk_req_valid", 64'(bus.walk_req_valid), 64'd0);
        check("rst_walk_req_addr", 64'(bus.walk_req_addr), 64'd0);
        check("rst_write_wen", 64'(bus.write_wen), 64'd0);
        check("rst_write_addr", 64'(bus.write_addr), 64'd0);
        check("rst_write_flags", 64'({bus.write_xstant, bus.write_invl, bus.fill_done}), 64'd0);

        for (int i = 0; i < 21; i++) begin
            cycle();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end

        cycle();
        quietInputs();
        walk_log.delete();
        fill0 = fill_cnt;
        bus.walk_req_ready = 1'b0;
        bus.miss_valid = 1'b1; bus.miss_addr = 51'h10;
        cycle(); bus.miss_valid = 1'b0;
        cycle(); bus.miss_valid = 1'b1; bus.miss_addr = 51'h10;
        cycle(); bus.miss_addr = 51'h20;
        cycle(); bus.miss_addr = 51'h10;
        cycle(); bus.miss_valid = 1'b0;
        runWalks(20);
        check("dedup_walk_count", 64'(walk_log.size()), 64'd2);
        check("dedup_walk0", 64'(walk_log.size() > 0 ? walk_log[0] : '1), 64'h10);
        check("dedup_walk1", 64'(walk_log.size() > 1 ? walk_log[1] : '1), 64'h20);
        check("dedup_fill_count", 64'(fill_cnt - fill0), 64'd2);

        walk_log.delete();
        bus.walk_req_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            cycle();
            bus.miss_valid = 1'b1;
            bus.miss_addr  = VA_W'(51'h100 + k);
        end
        cycle();
        bus.miss_valid = 1'b0;
        @(negedge clk);
        check("full_miss_ready_a", 64'(bus.miss_ready), 64'd0);
        cycle();
        @(negedge clk);
        check("full_miss_ready_b", 64'(bus.miss_ready), 64'd0);
        check("full_no_walk_yet", 64'(walk_log.size()), 64'd0);
        cycle();
        runWalks(40);
        check("wrap_walk_count", 64'(walk_log.size()), 64'(DEPTH + 1));
        for (int k = 0; k <= DEPTH; k++)
            check($sformatf("wrap_walk%0d", k),
                  64'(walk_log.size() > k ? walk_log[k] : '1), 64'h100 + 64'(k));
        @(negedge clk);
        check("wrap_miss_ready_after", 64'(bus.miss_ready), 64'd1);

        cycle();
        bus.walk_req_ready = 1'b1;
        bus.miss_valid = 1'b1; bus.miss_addr = 51'h55;
        cycle(); bus.miss_valid = 1'b0;
        cycle();
        cycle(); rst = 1'b0;
        wen0 = wen_cnt;
        cycle();
        cycle(); rst = 1'b1;
        walk_log.delete();
        cycle();
        bus.walk_rsp_valid = 1'b1; bus.walk_rsp_data0 = 64'h77;
        cycle(); bus.walk_rsp_valid = 1'b0;
        repeat (5) cycle();
        @(negedge clk);
        check("rstmid_no_write", 64'(wen_cnt - wen0), 64'd0);
        check("rstmid_no_walk", 64'(walk_log.size()), 64'd0);
        check("rstmid_miss_ready", 64'(bus.miss_ready), 64'd1);
        check("rstmid_inv_ready", 64'(bus.inv_ready), 64'd1);
        check("rstmid_walk_req_valid", 64'(bus.walk_req_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
